// File: rtl/stage_reg_fetch_pkg.sv
// Shared definitions for the fetch/issue stage: field widths, the
// address-mode and opcode codes, and the fetch state encoding.
package stage_reg_fetch_pkg;

   localparam int unsigned OPC_W  = 5;
   localparam int unsigned MODE_W = 3;
   localparam int unsigned ADDR_W = 8;

   localparam logic [MODE_W-1:0] MODE_IMPLIED = 3'b000;
   localparam logic [OPC_W-1:0]  OPC_HALT     = 5'h1F;

   typedef enum logic [2:0] {
      F_OP,
      D_OP,
      D_DATA,
      ISSUE,
      HALT
   } fetch_state_t;

   // Any mode other than the implied one carries one operand byte.
   function automatic logic has_operand(input logic [MODE_W-1:0] mode,
                                        input logic [MODE_W-1:0] implied);
      return mode != implied;
   endfunction

endpackage

// File: rtl/stage_reg_fetch_if.sv
// Fetch -> execute bundle with its valid/complete handshake.
interface stage_reg_fetch_if
   import stage_reg_fetch_pkg::*;
   ();

   logic [OPC_W-1:0]  StageRegInstr_out;
   logic [MODE_W-1:0] StageRegAddrMode_out;
   logic [7:0]        StageRegData_out;
   logic [ADDR_W-1:0] StageRegPCtr_out;
   logic              StageValid;
   logic [ADDR_W-1:0] NextPctr;
   logic              StageComplete;

   // Fetch side: drives the bundle, receives completion and next PC.
   modport master (
      output StageRegInstr_out, StageRegAddrMode_out, StageRegData_out,
             StageRegPCtr_out, StageValid,
      input  NextPctr, StageComplete
   );

   // Execute side.
   modport slave (
      input  StageRegInstr_out, StageRegAddrMode_out, StageRegData_out,
             StageRegPCtr_out, StageValid,
      output NextPctr, StageComplete
   );

endinterface

// File: rtl/stage_reg_fetch.sv
// Fetch/issue stage: reads 1- or 2-byte instructions from a synchronous
// instruction memory, presents the decoded bundle to execute and holds it
// until StageComplete, then redirects to NextPctr or the interrupt vector.
module stage_reg_fetch
   import stage_reg_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 8'h00,
   parameter logic [OPC_W-1:0]  HALT_OPCODE  = OPC_HALT,
   parameter logic [MODE_W-1:0] IMPLIED_MODE = MODE_IMPLIED
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_data,
   stage_reg_fetch_if.master stg,
   input  logic              irq_req,
   input  logic [ADDR_W-1:0] irq_vector,
   output logic              irq_ack,
   output logic [ADDR_W-1:0] irq_ret_pctr,
   output logic              halted
);

   fetch_state_t      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [OPC_W-1:0]  instr_q;
   logic [MODE_W-1:0] mode_q;
   logic [7:0]        data_q;
   logic [ADDR_W-1:0] pctr_q;
   logic              valid_q;
   logic              irq_pend_q;
   logic              irq_ack_q;
   logic [ADDR_W-1:0] irq_ret_q;
   logic              halted_q;
   logic              take_irq;

   // A request arriving on the same cycle as completion is taken at once.
   assign take_irq = irq_pend_q | irq_req;

   // Memory address follows the fetch state; the read returns next cycle.
   always_comb begin
      imem_addr = pc_q;
      case (state_q)
         F_OP:    imem_addr = pc_q;
         D_OP:    imem_addr = pc_q + 8'd1;
         D_DATA:  imem_addr = pc_q + 8'd1;
         default: imem_addr = pc_q;
      endcase
   end

   // Fetch FSM with registered bundle, interrupt and halt outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= F_OP;
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         mode_q     <= '0;
         data_q     <= '0;
         pctr_q     <= '0;
         valid_q    <= 1'b0;
         irq_pend_q <= 1'b0;
         irq_ack_q  <= 1'b0;
         irq_ret_q  <= '0;
         halted_q   <= 1'b0;
      end else begin
         irq_ack_q <= 1'b0;
         if (irq_req && state_q != HALT) irq_pend_q <= 1'b1;
         case (state_q)
            F_OP: state_q <= D_OP;
            D_OP: begin
               instr_q <= imem_data[7:3];
               mode_q  <= imem_data[2:0];
               if (has_operand(imem_data[2:0], IMPLIED_MODE)) begin
                  state_q <= D_DATA;
               end else begin
                  data_q  <= '0;
                  pctr_q  <= pc_q + 8'd1;
                  valid_q <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            D_DATA: begin
               data_q  <= imem_data;
               pctr_q  <= pc_q + 8'd2;
               valid_q <= 1'b1;
               state_q <= ISSUE;
            end
            ISSUE: begin
               if (stg.StageComplete) begin
                  valid_q <= 1'b0;
                  if (take_irq) begin
                     pc_q       <= irq_vector;
                     irq_ret_q  <= stg.NextPctr;
                     irq_ack_q  <= 1'b1;
                     irq_pend_q <= 1'b0;
                     state_q    <= F_OP;
                  end else if (instr_q == HALT_OPCODE) begin
                     halted_q <= 1'b1;
                     state_q  <= HALT;
                  end else begin
                     pc_q    <= stg.NextPctr;
                     state_q <= F_OP;
                  end
               end
            end
            default: state_q <= HALT;
         endcase
      end
   end

   assign stg.StageRegInstr_out    = instr_q;
   assign stg.StageRegAddrMode_out = mode_q;
   assign stg.StageRegData_out     = data_q;
   assign stg.StageRegPCtr_out     = pctr_q;
   assign stg.StageValid           = valid_q;
   assign irq_ack                  = irq_ack_q;
   assign irq_ret_pctr             = irq_ret_q;
   assign halted                   = halted_q;

endmodule
